// File: rtl/pe_mac_param_if.sv
//------------------------------------------------------------------------------
// pe_mac_param_if
//
// Purpose : Bundles the operand handshake and the result/forwarding signals
//           of one systolic MAC processing element. clk and rst are not part
//           of the bundle; they stay plain ports on the PE.
//
// Parameters
//   DATA_W   operand width (row/col data)
//   ACC_W    accumulator width
//
// Signals
//   in_valid   operand pair (row_in, col_in, clear_acc) valid this cycle
//   in_ready   PE can accept an operand pair this cycle
//   clear_acc  restart accumulation from the accepted product
//   row_in     operand A from the left neighbour
//   col_in     operand B from the upper neighbour
//   row_out    registered A forwarded to the right neighbour
//   col_out    registered B forwarded to the lower neighbour
//   fwd_valid  one-cycle pulse: row_out/col_out updated
//   acc_out    current accumulated sum
//   done_pe    one-cycle pulse: acc_out updated
//   ovf        sticky saturation flag
//
// Modports
//   master  : the side that supplies operands and observes results
//   slave   : the processing element itself
//------------------------------------------------------------------------------
interface pe_mac_param_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
);
   logic              in_valid;
   logic              in_ready;
   logic              clear_acc;
   logic [DATA_W-1:0] row_in;
   logic [DATA_W-1:0] col_in;
   logic [DATA_W-1:0] row_out;
   logic [DATA_W-1:0] col_out;
   logic              fwd_valid;
   logic [ACC_W-1:0]  acc_out;
   logic              done_pe;
   logic              ovf;

   modport master (
      output in_valid, clear_acc, row_in, col_in,
      input  in_ready, row_out, col_out, fwd_valid, acc_out, done_pe, ovf
   );

   modport slave (
      input  in_valid, clear_acc, row_in, col_in,
      output in_ready, row_out, col_out, fwd_valid, acc_out, done_pe, ovf
   );
endinterface

// File: rtl/pe_mac_param.sv
//------------------------------------------------------------------------------
// pe_mac_param
//
// Purpose : Parameterised multiply-accumulate processing element for a
//           systolic array. Accepts one (row, col) operand pair through a
//           valid/ready handshake, multiplies it over MUL_LAT cycles, then
//           adds the product into a saturating accumulator (or restarts the
//           accumulator when clear_acc was set) and forwards the operands to
//           the right/lower neighbours.
//
// Parameters
//   DATA_W   operand width                         (default 8)
//   ACC_W    accumulator width, >= 2*DATA_W         (default 20)
//   MUL_LAT  multiply latency in cycles, 1..15      (default 2)
//   SIGNED   0 = unsigned, 1 = two's complement     (default 0)
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   bus      pe_mac_param_if.slave (handshake, operands, results)
//
// Timing
//   Pair accepted at edge k  -> MUL for MUL_LAT edges, ACC for one edge,
//   results and done_pe/fwd_valid visible after edge k+MUL_LAT+1, next pair
//   accepted no earlier than edge k+MUL_LAT+2.
//------------------------------------------------------------------------------
module pe_mac_param #(
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 20,
   parameter int MUL_LAT = 2,
   parameter int SIGNED  = 0
) (
   input  logic           clk,
   input  logic           rst,
   pe_mac_param_if.slave  bus
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2
   } state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [DATA_W-1:0]   a_reg;
   logic [DATA_W-1:0]   b_reg;
   logic                clr_reg;
   logic [PROD_W-1:0]   prod_reg;
   logic [ACC_W-1:0]    acc_reg;
   logic [DATA_W-1:0]   row_reg;
   logic [DATA_W-1:0]   col_reg;
   logic                done_reg;
   logic                fwd_reg;
   logic                ovf_reg;
   logic                ready_reg;

   logic [PROD_W-1:0]   a_ext;
   logic [PROD_W-1:0]   b_ext;
   logic [PROD_W-1:0]   prod_next;
   logic [ACC_W-1:0]    prod_ext;
   logic [ACC_W:0]      sum_wide;
   logic                sat_hit;
   logic [ACC_W-1:0]    sat_val;
   logic [ACC_W-1:0]    acc_next;
   logic                ovf_next;

   //---------------------------------------------------------------------------
   // Signedness-dependent arithmetic. Operands are widened to the full product
   // width before multiplying, so a plain unsigned multiply yields the correct
   // low PROD_W bits for both interpretations.
   //---------------------------------------------------------------------------
   generate
      if (SIGNED != 0) begin : g_signed
         assign a_ext    = {{DATA_W{a_reg[DATA_W-1]}}, a_reg};
         assign b_ext    = {{DATA_W{b_reg[DATA_W-1]}}, b_reg};
         assign prod_ext = ACC_W'($signed(prod_reg));
         // One guard bit: overflow when the guard and the sign disagree.
         assign sum_wide = {acc_reg[ACC_W-1], acc_reg} + {prod_ext[ACC_W-1], prod_ext};
         assign sat_hit  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
         // Guard bit carries the true sign: negative clamps to min, else max.
         assign sat_val  = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin : g_unsigned
         assign a_ext    = {{DATA_W{1'b0}}, a_reg};
         assign b_ext    = {{DATA_W{1'b0}}, b_reg};
         assign prod_ext = ACC_W'(prod_reg);
         assign sum_wide = {1'b0, acc_reg} + {1'b0, prod_ext};
         assign sat_hit  = sum_wide[ACC_W];
         assign sat_val  = {ACC_W{1'b1}};
      end
   endgenerate

   assign prod_next = a_ext * b_ext;

   //---------------------------------------------------------------------------
   // Accumulator update value. A clear restarts from the product and drops the
   // sticky flag; the product always fits because ACC_W >= 2*DATA_W.
   //---------------------------------------------------------------------------
   always_comb begin
      acc_next = prod_ext;
      ovf_next = 1'b0;
      if (!clr_reg) begin
         acc_next = sum_wide[ACC_W-1:0];
         ovf_next = ovf_reg;
         if (sat_hit) begin
            acc_next = sat_val;
            ovf_next = 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Control FSM with registered outputs. in_ready is kept as its own register
   // that is high exactly while the FSM sits in IDLE.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         clr_reg   <= 1'b0;
         prod_reg  <= '0;
         acc_reg   <= '0;
         row_reg   <= '0;
         col_reg   <= '0;
         done_reg  <= 1'b0;
         fwd_reg   <= 1'b0;
         ovf_reg   <= 1'b0;
         ready_reg <= 1'b1;
      end else begin
         done_reg <= 1'b0;
         fwd_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.in_valid && ready_reg) begin
                  a_reg     <= bus.row_in;
                  b_reg     <= bus.col_in;
                  clr_reg   <= bus.clear_acc;
                  cnt_reg   <= CNT_W'(MUL_LAT - 1);
                  ready_reg <= 1'b0;
                  state_reg <= MUL;
               end
            end
            MUL: begin
               // Latched operands are stable here, so the product register
               // settles on the first MUL cycle and simply holds afterwards.
               prod_reg <= prod_next;
               if (cnt_reg == '0) begin
                  state_reg <= ACC;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ACC: begin
               acc_reg   <= acc_next;
               ovf_reg   <= ovf_next;
               row_reg   <= a_reg;
               col_reg   <= b_reg;
               done_reg  <= 1'b1;
               fwd_reg   <= 1'b1;
               ready_reg <= 1'b1;
               state_reg <= IDLE;
            end
            default: begin
               ready_reg <= 1'b1;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = ready_reg;
   assign bus.row_out   = row_reg;
   assign bus.col_out   = col_reg;
   assign bus.fwd_valid = fwd_reg;
   assign bus.acc_out   = acc_reg;
   assign bus.done_pe   = done_reg;
   assign bus.ovf       = ovf_reg;

endmodule

// File: doc/pe_mac_param.md
PE_MAC_PARAM -- requirements
Module: pe_mac_param

Interface
REQ-001 Parameter DATA_W, default 8, operand width of row/col data.
REQ-002 Parameter ACC_W, default 20, accumulator width; SHALL satisfy ACC_W >= 2*DATA_W.
REQ-003 Parameter MUL_LAT, default 2, multiply latency in cycles; legal range 1..15.
REQ-004 Parameter SIGNED, default 0; 0 = unsigned, 1 = two's-complement operands and accumulator.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  row_in/col_in/clear_acc valid this cycle.
REQ-008 in_ready  output  1  block can accept an operand pair this cycle.
REQ-009 clear_acc  input  1  with an accepted pair: restart accumulation from this product.
REQ-010 row_in  input  DATA_W  operand A from left neighbour.
REQ-011 col_in  input  DATA_W  operand B from upper neighbour.
REQ-012 row_out  output  DATA_W  registered A forwarded to right neighbour.
REQ-013 col_out  output  DATA_W  registered B forwarded to lower neighbour.
REQ-014 fwd_valid  output  1  one-cycle pulse: row_out/col_out updated; drives neighbour in_valid.
REQ-015 acc_out  output  ACC_W  current accumulated sum.
REQ-016 done_pe  output  1  one-cycle pulse: acc_out updated.
REQ-017 ovf  output  1  sticky saturation flag.

Function
REQ-018 Handshake: a pair is accepted on a rising edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored with no side effects.
REQ-019 FSM states IDLE, MUL, ACC; in_ready=1 only in IDLE.
REQ-020 IDLE -> MUL on acceptance; row_in, col_in, clear_acc latched into internal registers.
REQ-021 MUL: down-counter loaded with MUL_LAT-1 on entry; MUL -> ACC when counter = 0; product computed from latched operands only.
REQ-022 ACC lasts exactly one cycle, then -> IDLE.
REQ-023 On leaving ACC: acc_out, row_out, col_out updated; done_pe=1 and fwd_valid=1 for exactly one cycle.
REQ-024 Latency: pair accepted at edge k -> done_pe/fwd_valid high in cycle after edge k+MUL_LAT+1; next acceptance no earlier than edge k+MUL_LAT+2.
REQ-025 Product width 2*DATA_W; SIGNED=1 sign-extends product to ACC_W, SIGNED=0 zero-extends.
REQ-026 clear_acc latched = 1: acc_out <= extended product and ovf <= 0.
REQ-027 clear_acc latched = 0: acc_out <= acc_out + extended product, saturating.
REQ-028 Saturation, SIGNED=0: sum above 2^ACC_W-1 clamps to 2^ACC_W-1.
REQ-029 Saturation, SIGNED=1: clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
REQ-030 ovf set on any clamping; it stays set until a clear_acc accumulate or reset.
REQ-031 Outside the update cycle, acc_out, row_out and col_out SHALL hold their values.
REQ-032 Outside the update cycle, done_pe and fwd_valid SHALL be 0.
REQ-033 in_valid high continuously: pairs consumed back-to-back at a rate of one per MUL_LAT+2 cycles; no pair dropped or duplicated.

Reset
REQ-034 rst=1 at an edge: state <- IDLE; counter, latched operands, acc_out, row_out, col_out <- 0.
REQ-035 rst=1 at an edge: done_pe, fwd_valid, ovf <- 0; in_ready=1 in the following cycle.
REQ-036 rst SHALL take priority over in_valid; reset during MUL or ACC aborts the operation with no done_pe/fwd_valid pulse and no accumulator update.

Verification
REQ-037 Defaults; accept (3,5,clear=1) at edge 0 -> done_pe and fwd_valid high only after edge 3; acc_out=15, row_out=3, col_out=5, in_ready=0 during edges 1-2.
REQ-038 Then accept (4,6,clear=0) -> acc_out=39; then (2,2,clear=1) -> acc_out=4, ovf=0.
REQ-039 ACC_W=16; (255,255,clear=1) then (255,255,clear=0) -> acc_out=65535, ovf=1; then (1,1,clear=1) -> acc_out=1, ovf=0.
REQ-040 SIGNED=1; (-3,5,clear=1) -> acc_out=0xFFFF1 (-15); then (-128,-128,clear=0) -> acc_out=16369.
REQ-041 rst pulsed one cycle after acceptance (state MUL) -> no done_pe pulse; all outputs 0, in_ready=1 next cycle; following (7,7,clear=0) gives 49.
REQ-042 MUL_LAT=1 and 4, in_valid held high with 5 distinct pairs -> exactly 5 done_pe pulses spaced MUL_LAT+2 cycles, correct running sum, and pulses with in_ready=0 ignored.
